// File: rtl/irq_ctrl_pkg.sv
// Shared register offsets and field encodings for the interrupt controller.
// Nothing here has latency or backpressure of its own. Only constants and types are defined.
package irq_ctrl_pkg;

  typedef enum logic [4:0] {
    OFF_PEND  = 5'h00,
    OFF_EN    = 5'h04,
    OFF_MODE  = 5'h08,
    OFF_POL   = 5'h0C,
    OFF_CLAIM = 5'h10
  } reg_off_e;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;
  localparam logic POL_HIGH   = 1'b0;
  localparam logic POL_LOW    = 1'b1;

  localparam logic [31:0] CLAIM_NONE = 32'hFFFF_FFFF;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source input stage: 2-flop sync, polarity, rising-edge detect on the active level.
// act_o is 2 clk behind src_i; rise_o pulses in that same cycle. There is no backpressure.
module irq_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic src_i,
  input  logic pol_i,
  input  logic pol_nxt_i,
  input  logic reload_i,
  output logic act_o,
  output logic rise_o
);

  logic sync1_q, sync2_q, prev_q, prev_d;

  assign act_o  = sync2_q ^ pol_i;
  assign rise_o = act_o & ~prev_q;

  // On reconfiguration, preload the history with the act value seen next cycle.
  assign prev_d = reload_i ? (sync1_q ^ pol_nxt_i) : act_o;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= src_i;
      sync2_q <= sync1_q;
      prev_q  <= prev_d;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: level/edge sources, enable mask, core ack, bus registers; src->irq 3 clk, rdata 1 clk.
// No backpressure: gnt_o = req_i. Define IRQ_CTRL_CLAIM_EN to add the CLAIM register at 0x10.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC  = 16,
  parameter int FIRST_ID = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [4:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic               gnt_o,
  output logic               rvalid_o,
  output logic [31:0]        rdata_o,
  output logic [31:0]        irq_o,
  input  logic               irq_ack_i,
  input  logic [4:0]         irq_id_i
);

  logic [NUM_SRC-1:0] pend_q, pend_d, en_q, en_d, mode_q, mode_d, pol_q, pol_d;
  logic [NUM_SRC-1:0] act, rise, w1c_clr, ack_clr, claim_clr, clr, wmask;
  logic [31:0]        wr_dat, mask32, rd_dat;
  logic               wr, rd, reload, rvalid_q;
  logic [31:0]        rdata_q;
  logic               unused_wr_hi;

  assign wr     = req_i & we_i;
  assign rd     = req_i & ~we_i;
  assign gnt_o  = req_i;
  assign mask32 = be_mask(be_i);
  assign wr_dat = wdata_i & mask32;
  assign wmask  = mask32[NUM_SRC-1:0];
  assign unused_wr_hi = ^{wr_dat[31:NUM_SRC], mask32[31:NUM_SRC]};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_sync_edge u_sync (
      .clk       (clk),
      .rstn      (rstn),
      .src_i     (src_i[g]),
      .pol_i     (pol_q[g]),
      .pol_nxt_i (pol_d[g]),
      .reload_i  (reload),
      .act_o     (act[g]),
      .rise_o    (rise[g])
    );
  end

  always_comb begin
    en_d    = en_q;
    mode_d  = mode_q;
    pol_d   = pol_q;
    w1c_clr = '0;
    reload  = 1'b0;
    if (wr) begin
      case (addr_i)
        OFF_PEND: w1c_clr = wr_dat[NUM_SRC-1:0];
        OFF_EN:   en_d    = (en_q & ~wmask) | wr_dat[NUM_SRC-1:0];
        OFF_MODE: begin
          mode_d = (mode_q & ~wmask) | wr_dat[NUM_SRC-1:0];
          reload = 1'b1;
        end
        OFF_POL: begin
          pol_d  = (pol_q & ~wmask) | wr_dat[NUM_SRC-1:0];
          reload = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_clr[i] = irq_ack_i && (irq_id_i == 5'(FIRST_ID + i));
    end
  end

`ifdef IRQ_CTRL_CLAIM_EN
  logic       claim_vld, claim_hit;
  logic [4:0] claim_idx;

  // Scan downward so the lowest pending-and-enabled index wins.
  always_comb begin
    claim_vld = 1'b0;
    claim_idx = 5'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend_q[i] && en_q[i]) begin
        claim_vld = 1'b1;
        claim_idx = 5'(i);
      end
    end
  end

  assign claim_hit = rd && (addr_i == OFF_CLAIM) && claim_vld;

  always_comb begin
    claim_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_clr[i] = claim_hit && (claim_idx == 5'(i));
    end
  end
`else
  assign claim_clr = '0;
`endif

  assign clr = w1c_clr | ack_clr | claim_clr;

  always_comb begin
    pend_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pend_d[i] = (mode_q[i] == MODE_EDGE) ? (rise[i] | (pend_q[i] & ~clr[i])) : act[i];
    end
  end

  always_comb begin
    rd_dat = '0;
    case (addr_i)
      OFF_PEND:  rd_dat = 32'(pend_q);
      OFF_EN:    rd_dat = 32'(en_q);
      OFF_MODE:  rd_dat = 32'(mode_q);
      OFF_POL:   rd_dat = 32'(pol_q);
`ifdef IRQ_CTRL_CLAIM_EN
      OFF_CLAIM: rd_dat = claim_vld ? 32'(claim_idx) : CLAIM_NONE;
`endif
      default:   rd_dat = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q   <= '0;
      en_q     <= '0;
      mode_q   <= '0;
      pol_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      pend_q   <= pend_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      pol_q    <= pol_d;
      rvalid_q <= req_i;
      rdata_q  <= rd ? rd_dat : 32'd0;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign irq_o    = 32'(pend_q & en_q) << FIRST_ID;

endmodule
